// File: rtl/signed_calc.sv
// signed_calc: two-stage registered 5x5 signed multiplier with a 9-bit
// saturating result. Stage 1 holds the operands; stage 2 holds the product.
// The product is formed from an explicit array of sign-extended partial
// products rather than the '*' operator.
//
// Handshake: valid-only streaming. o_valid is i_valid delayed by exactly two
// rising edges. There is no ready/backpressure, so a result is produced every
// cycle. The datapath also computes when i_valid is low, which keeps o_fs a
// deterministic function of the captured operands.
module signed_calc (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [4:0] i_as,
  input  logic [4:0] i_bs,
  input  logic       i_valid,
  output logic [8:0] o_fs,
  output logic       o_valid,
  output logic       o_ovf
);

  // Stage 1 operand registers
  logic [4:0] a_q;
  logic [4:0] b_q;
  logic       v1_q;

  // Stage 2 result registers
  logic [8:0] fs_q;
  logic       ovf_q;
  logic       v2_q;

  // Next-state values for stage 2
  logic [9:0] a_ext;
  logic [9:0] pp [5];
  logic [9:0] prod_d;
  logic [8:0] fs_d;
  logic       ovf_d;

  // Stage 1: capture operands and their valid bit on every edge
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      a_q  <= '0;
      b_q  <= '0;
      v1_q <= 1'b0;
    end else begin
      a_q  <= i_as;
      b_q  <= i_bs;
      v1_q <= i_valid;
    end
  end

  // Partial-product array: rows 0..3 add A<<i, row 4 carries weight -16
  // and is subtracted. 10 bits are enough to hold the full range -240..256.
  always_comb begin
    a_ext  = {{5{a_q[4]}}, a_q};
    prod_d = '0;
    for (int i = 0; i < 5; i++) begin
      pp[i] = b_q[i] ? (a_ext << i) : 10'd0;
    end
    for (int i = 0; i < 4; i++) begin
      prod_d = prod_d + pp[i];
    end
    prod_d = prod_d - pp[4];
  end

  // Saturation: +256 (only from -16 * -16) is the single value that does
  // not fit in 9 signed bits; clamp it to +255 and raise the flag.
  always_comb begin
    ovf_d = (prod_d == 10'd256);
    fs_d  = ovf_d ? 9'h0FF : prod_d[8:0];
  end

  // Stage 2: register the result, overflow flag and valid bit
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      fs_q  <= '0;
      ovf_q <= 1'b0;
      v2_q  <= 1'b0;
    end else begin
      fs_q  <= fs_d;
      ovf_q <= ovf_d;
      v2_q  <= v1_q;
    end
  end

  assign o_fs    = fs_q;
  assign o_ovf   = ovf_q;
  assign o_valid = v2_q;

endmodule

// File: tb/tb_signed_calc.sv
// Testbench for signed_calc: directed scenarios, random stream and an
// exhaustive operand sweep, all scored against a plain-arithmetic model.
module tb_signed_calc;

  logic       i_clk;
  logic       i_rst_n;
  logic [4:0] i_as;
  logic [4:0] i_bs;
  logic       i_valid;
  logic [8:0] o_fs;
  logic       o_valid;
  logic       o_ovf;

  int errors = 0;
  int checks = 0;

  // Expected output words {valid, ovf, fs[8:0]}, one per clock edge
  logic [10:0] exp_q[$];

  signed_calc dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_as    (i_as),
    .i_bs    (i_bs),
    .i_valid (i_valid),
    .o_fs    (o_fs),
    .o_valid (o_valid),
    .o_ovf   (o_ovf)
  );

  // Clock / reset block
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Reference: integer product, saturated to +255 when it exceeds 9-bit range
  function automatic logic [10:0] ref_model(input int a, input int b, input bit v);
    int p;
    logic [8:0] fs;
    logic ovf;
    p = a * b;
    if (p > 255) begin
      fs  = 9'h0FF;
      ovf = 1'b1;
    end else begin
      fs  = p[8:0];
      ovf = 1'b0;
    end
    return {v, ovf, fs};
  endfunction

  // Expected pipeline contents just after reset: stage 2 will load the
  // cleared stage 1, i.e. a zero, non-valid word on the first edge.
  task automatic seed_after_reset();
    exp_q.delete();
    exp_q.push_back(11'd0);
  endtask

  // Driver: apply one operand pair, clock it, return the word that must be
  // on the outputs now (the one applied one step earlier).
  task automatic step(input int a, input int b, input bit v, output logic [10:0] e);
    logic [4:0] a5;
    logic [4:0] b5;
    a5 = a[4:0];
    b5 = b[4:0];
    i_as    = a5;
    i_bs    = b5;
    i_valid = v;
    @(posedge i_clk);
    #1;
    exp_q.push_back(ref_model(a, b, v));
    e = exp_q.pop_front();
  endtask

  task automatic do_reset();
    i_rst_n = 1'b0;
    i_as    = '0;
    i_bs    = '0;
    i_valid = 1'b0;
    repeat (2) @(posedge i_clk);
    #2;
    i_rst_n = 1'b1;
    seed_after_reset();
  endtask

  task automatic test_reset();
    logic [10:0] e;
    i_rst_n = 1'b0;
    i_as    = '0;
    i_bs    = '0;
    i_valid = 1'b0;
    #3;
    checks++;
    if ({o_valid, o_ovf, o_fs} !== 11'd0) begin
      errors++;
      $display("FAIL reset_state: got v=%b ovf=%b fs=%h, want 0/0/000", o_valid, o_ovf, o_fs);
    end
    repeat (2) @(posedge i_clk);
    #2;
    i_rst_n = 1'b1;
    seed_after_reset();
    // A=0, B=0, valid: result 0 with valid after two edges
    step(0, 0, 1, e);
    checks++;
    if (o_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_first_edge: got v=%b want 0", o_valid);
    end
    step(0, 0, 0, e);
    checks++;
    if ({o_valid, o_ovf, o_fs} !== {1'b1, 1'b0, 9'h000}) begin
      errors++;
      $display("FAIL zero_zero: got v=%b ovf=%b fs=%h, want 1/0/000", o_valid, o_ovf, o_fs);
    end
  endtask

  task automatic test_directed();
    logic [10:0] e;
    int a_v[8] = '{-15, -15, 1, -16, -1, -16, -16, 0};
    int b_v[8] = '{ 15,   0, 3,  15, -1, -16, -15, 0};
    logic [10:0] want[8] = '{{2'b10, 9'h11F}, {2'b10, 9'h000}, {2'b10, 9'h003},
                             {2'b10, 9'h110}, {2'b10, 9'h001}, {2'b11, 9'h0FF},
                             {2'b10, 9'h0F0}, {2'b10, 9'h000}};
    step(a_v[0], b_v[0], 1, e);
    for (int i = 0; i < 8; i++) begin
      step((i < 7) ? a_v[i+1] : 0, (i < 7) ? b_v[i+1] : 0, 1, e);
      checks++;
      if ({o_valid, o_ovf, o_fs} !== want[i] || e !== want[i]) begin
        errors++;
        $display("FAIL directed_%0d: got v=%b ovf=%b fs=%h, want %h", i, o_valid, o_ovf, o_fs, want[i]);
      end
    end
  endtask

  task automatic test_zero_operand();
    logic [10:0] e;
    for (int i = 0; i < 12; i++) begin
      int other;
      other = $urandom_range(31) - 16;
      if (i % 2 == 0) step(0, other, 1, e);
      else            step(other, 0, 1, e);
      if (i > 0) begin
        checks++;
        if ({o_valid, o_ovf, o_fs} !== {2'b10, 9'h000}) begin
          errors++;
          $display("FAIL zero_operand_%0d: got v=%b ovf=%b fs=%h, want 1/0/000", i, o_valid, o_ovf, o_fs);
        end
      end
    end
    step(0, 0, 0, e);
  endtask

  task automatic test_back_to_back();
    logic [10:0] e;
    int a_v[7] = '{3, -7, 12, -16, 5, 9, -2};
    int b_v[7] = '{4, 6, -11, 1, 5, -3, -8};
    bit v_v[7] = '{1, 1, 1, 1, 0, 1, 1};
    for (int i = 0; i < 9; i++) begin
      if (i < 7) step(a_v[i], b_v[i], v_v[i], e);
      else       step(0, 0, 0, e);
      checks++;
      if ({o_valid, o_ovf, o_fs} !== e) begin
        errors++;
        $display("FAIL back_to_back_%0d: got %b%b_%h want %h", i, o_valid, o_ovf, o_fs, e);
      end
    end
  endtask

  task automatic test_random();
    logic [10:0] e;
    for (int i = 0; i < 300; i++) begin
      step(int'($urandom_range(31)) - 16, int'($urandom_range(31)) - 16, bit'($urandom_range(1)), e);
      checks++;
      if ({o_valid, o_ovf, o_fs} !== e) begin
        errors++;
        $display("FAIL random_%0d: got %b%b_%h want %h", i, o_valid, o_ovf, o_fs, e);
      end
    end
  endtask

  task automatic test_reset_midflight();
    logic [10:0] e;
    step(7, 7, 1, e);
    step(-9, 13, 1, e);
    #3;
    i_rst_n = 1'b0;
    #1;
    checks++;
    if ({o_valid, o_ovf, o_fs} !== 11'd0) begin
      errors++;
      $display("FAIL async_reset: got v=%b ovf=%b fs=%h, want 0/0/000", o_valid, o_ovf, o_fs);
    end
    #2;
    i_rst_n = 1'b1;
    seed_after_reset();
    for (int i = 0; i < 4; i++) begin
      step(-6 + i, 11 - i, 1, e);
      checks++;
      if ({o_valid, o_ovf, o_fs} !== e) begin
        errors++;
        $display("FAIL after_reset_%0d: got %b%b_%h want %h", i, o_valid, o_ovf, o_fs, e);
      end
    end
  endtask

  task automatic test_sweep();
    logic [10:0] e;
    for (int a = -16; a < 16; a++) begin
      for (int b = -16; b < 16; b++) begin
        step(a, b, 1, e);
        checks++;
        if ({o_valid, o_ovf, o_fs} !== e) begin
          errors++;
          $display("FAIL sweep_%0d_%0d: got %b%b_%h want %h", a, b, o_valid, o_ovf, o_fs, e);
        end
      end
    end
    step(0, 0, 0, e);
    checks++;
    if ({o_valid, o_ovf, o_fs} !== e) begin
      errors++;
      $display("FAIL sweep_drain: got %b%b_%h want %h", o_valid, o_ovf, o_fs, e);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_zero_operand();
    test_back_to_back();
    test_random();
    test_reset_midflight();
    do_reset();
    test_sweep();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
